// File: rtl/inst_pc_sequencer_if.sv
// Bus between the PC sequencer and its environment: start/stop control,
// loop-controller decisions, and the PC / status outputs.
interface inst_pc_sequencer_if #(
  parameter int unsigned InstMemAddrWidth = 32,
  parameter int unsigned InstCountWidth   = 32
);
  logic                        clr_i;
  logic                        start_i;
  logic                        stall_i;
  logic                        dbg_en_i;
  logic                        dbg_step_i;
  logic                        inst_loop_en_i;
  logic [InstMemAddrWidth-1:0] inst_end_addr_i;
  logic                        inst_jump_i;
  logic [InstMemAddrWidth-1:0] inst_jump_addr_i;
  logic                        inst_loop_done_i;
  logic [InstMemAddrWidth-1:0] inst_pc_o;
  logic                        inst_valid_o;
  logic                        inst_advance_o;
  logic [InstCountWidth-1:0]   inst_count_o;
  logic                        busy_o;
  logic                        done_o;
  logic                        err_o;

  modport slave (
    input  clr_i, start_i, stall_i, dbg_en_i, dbg_step_i, inst_loop_en_i,
           inst_end_addr_i, inst_jump_i, inst_jump_addr_i, inst_loop_done_i,
    output inst_pc_o, inst_valid_o, inst_advance_o, inst_count_o,
           busy_o, done_o, err_o
  );

  modport master (
    output clr_i, start_i, stall_i, dbg_en_i, dbg_step_i, inst_loop_en_i,
           inst_end_addr_i, inst_jump_i, inst_jump_addr_i, inst_loop_done_i,
    input  inst_pc_o, inst_valid_o, inst_advance_o, inst_count_o,
           busy_o, done_o, err_o
  );
endinterface

// File: rtl/inst_pc_sequencer.sv
// Instruction PC sequencer: owns the PC and IDLE/RUN/DONE state, retires one
// instruction per advance and traps out-of-range next PCs.
module inst_pc_sequencer #(
  parameter int unsigned InstMemAddrWidth = 32,
  parameter int unsigned InstMemDepth     = 256,
  parameter int unsigned InstCountWidth   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  inst_pc_sequencer_if.slave    bus
);
  localparam int unsigned AW = InstMemAddrWidth;
  localparam int unsigned CW = InstCountWidth;
  // One extra bit so pc+1 at the top of the address space is not lost.
  localparam logic [AW:0] Depth = (AW+1)'(InstMemDepth);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  logic          advance;
  logic          stop;
  logic [AW:0]   next_pc;
  logic          oor;

  always_comb begin
    advance = (state_q == StRun) && !bus.stall_i && (!bus.dbg_en_i || bus.dbg_step_i);
    stop    = bus.inst_loop_en_i ? bus.inst_loop_done_i
                                 : (pc_q == bus.inst_end_addr_i);
    next_pc = (bus.inst_loop_en_i && bus.inst_jump_i) ? {1'b0, bus.inst_jump_addr_i}
                                                      : {1'b0, pc_q} + (AW+1)'(1);
    oor     = next_pc >= Depth;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (bus.clr_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (bus.start_i) begin
          state_q <= StRun;
          pc_q    <= '0;
          cnt_q   <= '0;
          err_q   <= 1'b0;
        end
        StRun: if (advance) begin
          cnt_q <= cnt_q + CW'(1);
          if (stop) begin
            state_q <= StDone;
          end else if (oor) begin
            // Trap: keep the offending instruction's PC for debug.
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            pc_q <= next_pc[AW-1:0];
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inst_pc_o      = pc_q;
  assign bus.inst_count_o   = cnt_q;
  assign bus.inst_valid_o   = (state_q == StRun);
  assign bus.busy_o         = (state_q == StRun);
  assign bus.done_o         = (state_q == StDone);
  assign bus.err_o          = err_q;
  assign bus.inst_advance_o = advance;
endmodule

// File: tb/tb_inst_pc_sequencer.sv
// Bench for inst_pc_sequencer: expected PC traces are built from the program
// rules up front, then replayed against the DUT under random stall/debug.
module tb_inst_pc_sequencer;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int BOUND = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_pc_sequencer_if #(.InstMemAddrWidth(AW), .InstCountWidth(CW)) bus ();

  inst_pc_sequencer #(
    .InstMemAddrWidth(AW), .InstMemDepth(DEPTH), .InstCountWidth(CW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {bit stall; bit dbg_en; bit step;} stim_t;
  stim_t script[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.clr_i = 0; bus.start_i = 0; bus.stall_i = 0; bus.dbg_en_i = 0;
    bus.dbg_step_i = 0; bus.inst_jump_i = 0; bus.inst_loop_done_i = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    32'(bus.inst_pc_o), 0);
    chk({tag, "_cnt"},   32'(bus.inst_count_o), 0);
    chk({tag, "_valid"}, 32'(bus.inst_valid_o), 0);
    chk({tag, "_adv"},   32'(bus.inst_advance_o), 0);
    chk({tag, "_busy"},  32'(bus.busy_o), 0);
    chk({tag, "_done"},  32'(bus.done_o), 0);
    chk({tag, "_err"},   32'(bus.err_o), 0);
  endtask

  // loop_en=1: end_a/lj/lc describe a single loop (end, jump target, iterations).
  // loop_en=0: end_a is the last program address.
  task automatic run_program(input bit loop_en, input int end_a, input int lj, input int lc,
                             input int stall_pct, input bit dbg, input bit poke_start);
    int    trace[$];
    bit    exp_err, fin, adv, at_end;
    int    pc, visits, nxt, k, dv, cyc, last;
    stim_t s;
    pc = 0; visits = 0; exp_err = 0; fin = 0; nxt = 0;
    while (!fin) begin
      trace.push_back(pc);
      if (pc == end_a) begin
        visits++;
        if (!loop_en || visits == lc) fin = 1;
        else nxt = lj;
      end else nxt = pc + 1;
      if (!fin && nxt >= DEPTH) begin exp_err = 1; fin = 1; end
      if (!fin) pc = nxt;
    end
    last = trace[trace.size()-1];

    bus.start_i = 1; bus.inst_loop_en_i = loop_en;
    bus.inst_end_addr_i = 8'(end_a); bus.inst_jump_addr_i = 8'(lj);
    @(negedge clk);
    k = 0; dv = 0; cyc = 0;
    while (k < trace.size() && cyc < BOUND) begin
      if (script.size() > 0) s = script.pop_front();
      else begin
        s.stall  = $urandom_range(99) < stall_pct;
        s.dbg_en = dbg;
        s.step   = $urandom_range(1) == 1;
      end
      bus.stall_i = s.stall; bus.dbg_en_i = s.dbg_en; bus.dbg_step_i = s.step;
      bus.start_i = poke_start && ($urandom_range(1) == 1);
      at_end = loop_en && trace[k] == end_a;
      if (loop_en) begin
        bus.inst_jump_i      = at_end && (dv + 1 < lc);
        bus.inst_loop_done_i = at_end && (dv + 1 == lc);
      end else begin
        bus.inst_jump_i      = $urandom_range(1) == 1;
        bus.inst_loop_done_i = $urandom_range(1) == 1;
      end
      adv = !s.stall && (!s.dbg_en || s.step);
      #1;
      chk("run_pc",    32'(bus.inst_pc_o), trace[k]);
      chk("run_cnt",   32'(bus.inst_count_o), k % (1 << CW));
      chk("run_adv",   32'(bus.inst_advance_o), 32'(adv));
      chk("run_busy",  32'(bus.busy_o), 1);
      chk("run_valid", 32'(bus.inst_valid_o), 1);
      chk("run_done",  32'(bus.done_o), 0);
      chk("run_err",   32'(bus.err_o), 0);
      @(negedge clk);
      cyc++;
      if (adv) begin
        if (at_end) dv++;
        k++;
      end
    end
    chk("run_len", k, trace.size());
    idle_inputs();
    #1;
    chk("done_pulse", 32'(bus.done_o), 1);
    chk("done_busy",  32'(bus.busy_o), 0);
    chk("done_adv",   32'(bus.inst_advance_o), 0);
    chk("done_pc",    32'(bus.inst_pc_o), last);
    chk("done_cnt",   32'(bus.inst_count_o), trace.size() % (1 << CW));
    chk("done_err",   32'(bus.err_o), 32'(exp_err));
    @(negedge clk); #1;
    chk("idle_done",  32'(bus.done_o), 0);
    chk("idle_busy",  32'(bus.busy_o), 0);
    chk("idle_pc",    32'(bus.inst_pc_o), last);
    chk("idle_cnt",   32'(bus.inst_count_o), trace.size() % (1 << CW));
    chk("idle_err",   32'(bus.err_o), 32'(exp_err));
  endtask

  initial begin
    idle_inputs();
    bus.inst_loop_en_i = 0; bus.inst_end_addr_i = '0; bus.inst_jump_addr_i = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1;
    @(negedge clk); #1;
    chk_reset_vals("post_reset");

    // Linear 0..4, then loop end 3 / jump 1 / count 3.
    run_program(0, 4, 0, 1, 0, 0, 0);
    run_program(1, 3, 1, 3, 0, 0, 0);

    // Stall three cycles at pc=2, then two debug pulses separated by idle cycles.
    script.push_back('{0, 0, 0}); script.push_back('{0, 0, 0});
    repeat (3) script.push_back('{1, 0, 0});
    script.push_back('{0, 1, 1}); script.push_back('{0, 1, 0});
    script.push_back('{0, 1, 0}); script.push_back('{0, 1, 1});
    script.push_back('{0, 1, 0});
    run_program(0, 6, 0, 1, 0, 0, 0);
    script.delete();

    // Out-of-range jump at pc=2, linear run off the end, then a clean program.
    run_program(1, 2, 9, 3, 0, 0, 0);
    run_program(0, 9, 0, 1, 0, 0, 1);
    run_program(0, 0, 0, 1, 0, 0, 0);

    // Clear together with start at pc=5.
    bus.start_i = 1; bus.inst_loop_en_i = 0; bus.inst_end_addr_i = 8'd7;
    @(negedge clk);
    bus.start_i = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.start_i = 1;
      @(negedge clk);
      bus.start_i = 0;
    end
    #1 chk("clr_pre_pc", 32'(bus.inst_pc_o), 5);
    bus.clr_i = 1; bus.start_i = 1;
    @(negedge clk);
    idle_inputs();
    #1 chk_reset_vals("clr");
    @(negedge clk); #1;
    chk_reset_vals("clr_hold");

    // Asynchronous reset mid-run.
    bus.start_i = 1; bus.inst_end_addr_i = 8'd7;
    @(negedge clk);
    bus.start_i = 0;
    repeat (3) @(negedge clk);
    #1 chk("arst_pre_pc", 32'(bus.inst_pc_o), 3);
    #1 rst_n = 0;
    #1 chk_reset_vals("arst");
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("arst_idle");

    // Randomized programs.
    for (int r = 0; r < 14; r++) begin
      int e, j, c;
      if ($urandom_range(1) == 1) begin
        e = $urandom_range(7, 1);
        j = ($urandom_range(5) == 0) ? $urandom_range(12, 8) : $urandom_range(e, 0);
        c = $urandom_range(5, 1);
        run_program(1, e, j, c, $urandom_range(40), $urandom_range(3) == 0, 1);
      end else begin
        run_program(0, $urandom_range(9), 0, 1, $urandom_range(40), $urandom_range(3) == 0, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
